// File: rtl/dawg_initiator.sv
// DAWG cache-partition initiator: accepts host OS/user commands, drives the
// cacheline request interface, returns hit/miss responses and keeps statistics.
`ifndef NUM_WAYS
`define NUM_WAYS 4
`endif
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 8
`endif

module dawg_initiator #(
  parameter int unsigned NUM_WAYS   = `NUM_WAYS,
  parameter int unsigned ADDR_WIDTH = `ADDR_WIDTH,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_os,
  input  logic [NUM_WAYS-1:0]   cmd_hitmap,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  output logic                  os_req,
  output logic [NUM_WAYS-1:0]   hitmap,
  output logic                  user_req,
  output logic [ADDR_WIDTH-1:0] addr,
  input  logic                  hit,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic                  rsp_hit,
  input  logic                  cnt_clr,
  output logic [CNT_WIDTH-1:0]  hit_cnt,
  output logic [CNT_WIDTH-1:0]  miss_cnt
);

  typedef enum logic [2:0] {
    IDLE,
    OS_ISSUE,
    USER_ISSUE,
    USER_WAIT,
    RESP
  } state_e;

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  state_e                state_q, state_d;
  logic [NUM_WAYS-1:0]   hitmap_q, hitmap_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  rsp_hit_q, rsp_hit_d;
  logic [CNT_WIDTH-1:0]  hit_cnt_q, hit_cnt_d;
  logic [CNT_WIDTH-1:0]  miss_cnt_q, miss_cnt_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      hitmap_q   <= '0;
      addr_q     <= '0;
      rsp_hit_q  <= 1'b0;
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      hitmap_q   <= hitmap_d;
      addr_q     <= addr_d;
      rsp_hit_q  <= rsp_hit_d;
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    hitmap_d   = hitmap_q;
    addr_d     = addr_q;
    rsp_hit_d  = rsp_hit_q;
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;

    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          if (cmd_os) begin
            hitmap_d = cmd_hitmap;
            state_d  = OS_ISSUE;
          end else begin
            addr_d  = cmd_addr;
            state_d = USER_ISSUE;
          end
        end
      end
      OS_ISSUE:   state_d = IDLE;
      USER_ISSUE: state_d = USER_WAIT;
      USER_WAIT: begin
        rsp_hit_d = hit;
        if (hit) begin
          if (!(&hit_cnt_q)) hit_cnt_d = hit_cnt_q + CNT_ONE;
        end else begin
          if (!(&miss_cnt_q)) miss_cnt_d = miss_cnt_q + CNT_ONE;
        end
        state_d = RESP;
      end
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Clear overrides any increment taken above in the same cycle.
    if (cnt_clr) begin
      hit_cnt_d  = '0;
      miss_cnt_d = '0;
    end
  end

  assign cmd_ready = (state_q == IDLE);
  assign os_req    = (state_q == OS_ISSUE);
  assign user_req  = (state_q == USER_ISSUE);
  assign rsp_valid = (state_q == RESP);
  assign rsp_hit   = rsp_hit_q;
  assign hitmap    = hitmap_q;
  assign addr      = addr_q;
  assign hit_cnt   = hit_cnt_q;
  assign miss_cnt  = miss_cnt_q;

endmodule

// File: tb/tb_dawg_initiator.sv
// Randomized bench for dawg_initiator, checked against a cycle-count model of
// each transaction's timeline.
module tb_dawg_initiator;

  localparam int unsigned NW = 4;
  localparam int unsigned AW = 8;
  localparam int unsigned CW = 2;
  localparam int CNT_MAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          reset;
  logic          cmd_valid, cmd_ready, cmd_os;
  logic [NW-1:0] cmd_hitmap;
  logic [AW-1:0] cmd_addr;
  logic          os_req, user_req;
  logic [NW-1:0] hitmap;
  logic [AW-1:0] addr;
  logic          hit, rsp_valid, rsp_ready, rsp_hit, cnt_clr;
  logic [CW-1:0] hit_cnt, miss_cnt;

  int tests_run = 0;
  int tests_failed = 0;

  // Model: age = cycles since acceptance (0 = no transaction in flight).
  int        m_age = 0;
  bit        m_os = 1'b0;
  bit [NW-1:0] m_hitmap = '0;
  bit [AW-1:0] m_addr = '0;
  bit        m_rsp_hit = 1'b0;
  int        m_hits = 0, m_misses = 0;

  dawg_initiator #(.NUM_WAYS(NW), .ADDR_WIDTH(AW), .CNT_WIDTH(CW)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_os(cmd_os),
    .cmd_hitmap(cmd_hitmap), .cmd_addr(cmd_addr),
    .os_req(os_req), .hitmap(hitmap), .user_req(user_req), .addr(addr),
    .hit(hit), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_hit(rsp_hit),
    .cnt_clr(cnt_clr), .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_age = 0; m_os = 1'b0; m_hitmap = '0; m_addr = '0;
    m_rsp_hit = 1'b0; m_hits = 0; m_misses = 0;
  endfunction

  function automatic void model_edge();
    if (m_age == 0) begin
      if (cmd_valid) begin
        m_os  = cmd_os;
        m_age = 1;
        if (cmd_os) m_hitmap = cmd_hitmap;
        else        m_addr   = cmd_addr;
      end
    end else if (m_os) begin
      m_age = 0;
    end else if (m_age == 1) begin
      m_age = 2;
    end else if (m_age == 2) begin
      m_rsp_hit = hit;
      if (hit) m_hits   = (m_hits   < CNT_MAX) ? m_hits + 1   : CNT_MAX;
      else     m_misses = (m_misses < CNT_MAX) ? m_misses + 1 : CNT_MAX;
      m_age = 3;
    end else if (rsp_ready) begin
      m_age = 0;
    end
    if (cnt_clr) begin
      m_hits = 0; m_misses = 0;
    end
  endfunction

  task automatic compare_all();
    bit exp_rv;
    exp_rv = !m_os && (m_age == 3);
    check("cmd_ready", cmd_ready, m_age == 0);
    check("os_req",    os_req,    m_os && (m_age == 1));
    check("user_req",  user_req,  !m_os && (m_age == 1));
    check("rsp_valid", rsp_valid, exp_rv);
    if (exp_rv) check("rsp_hit", rsp_hit, m_rsp_hit);
    check("hitmap",    hitmap,    m_hitmap);
    check("addr",      addr,      m_addr);
    check("hit_cnt",   hit_cnt,   m_hits);
    check("miss_cnt",  miss_cnt,  m_misses);
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
  endtask

  task automatic idle_inputs();
    cmd_valid = 1'b0; cmd_os = 1'b0; cmd_hitmap = '0; cmd_addr = '0;
    hit = 1'b0; rsp_ready = 1'b0; cnt_clr = 1'b0;
  endtask

  initial begin
    reset = 1'b0;
    idle_inputs();
    #12;
    check("rst_cmd_ready", cmd_ready, 1);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_hit_cnt",   hit_cnt,   0);
    check("rst_hitmap",    hitmap,    0);
    reset = 1'b1;

    // OS command with mask 0011, then an idle cycle.
    cmd_valid = 1'b1; cmd_os = 1'b1; cmd_hitmap = 4'b0011;
    step();
    idle_inputs();
    step();
    step();

    // User command 0x5A, hit on the wait cycle, response accepted at once.
    cmd_valid = 1'b1; cmd_addr = 8'h5A;
    step();
    idle_inputs();
    step();
    hit = 1'b1; rsp_ready = 1'b1;
    step();
    step();
    idle_inputs();
    step();

    // User miss with response stalled for four cycles.
    cmd_valid = 1'b1; cmd_addr = 8'hC3;
    step();
    idle_inputs();
    for (int i = 0; i < 6; i++) step();
    rsp_ready = 1'b1;
    step();
    idle_inputs();

    // Drive hit_cnt into saturation, then clear alongside a hit.
    for (int n = 0; n < 5; n++) begin
      cmd_valid = 1'b1; cmd_addr = n[AW-1:0];
      step();
      cmd_valid = 1'b0; hit = 1'b1; rsp_ready = 1'b1;
      step();
      if (n == 4) cnt_clr = 1'b1;
      step();
      step();
      idle_inputs();
    end

    for (int i = 0; i < 600; i++) begin
      cmd_valid  = ($urandom_range(0, 2) != 0);
      cmd_os     = ($urandom_range(0, 3) == 0);
      cmd_hitmap = NW'($urandom);
      cmd_addr   = AW'($urandom);
      hit        = $urandom_range(0, 1) == 1;
      rsp_ready  = ($urandom_range(0, 2) != 0);
      cnt_clr    = ($urandom_range(0, 39) == 0);
      step();
    end

    // Reset asserted while waiting for the cacheline hit.
    idle_inputs();
    for (int i = 0; i < 8 && m_age != 0; i++) begin
      rsp_ready = 1'b1;
      step();
    end
    idle_inputs();
    cmd_valid = 1'b1; cmd_os = 1'b0; cmd_addr = 8'h77;
    for (int i = 0; i < 20 && !(!m_os && m_age == 2); i++) begin
      step();
      cmd_valid = 1'b0;
    end
    check("reach_user_wait", (!m_os && m_age == 2), 1);
    hit = 1'b1;
    reset = 1'b0;
    model_reset();
    #1;
    compare_all();
    check("abort_rsp_hit", rsp_hit, 0);
    #2;
    reset = 1'b1;
    idle_inputs();
    for (int i = 0; i < 4; i++) step();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
